// File: rtl/passcode_pkg.sv
// Shared types and default parameter values for the passcode checker slice.
// The key-priority helper is kept here so every consumer resolves same-cycle strobes identically.
package passcode_pkg;

    localparam int DEF_DIGIT_W        = 4;
    localparam int DEF_RADIX          = 10;
    localparam int DEF_MAX_DIGITS     = 6;
    localparam int DEF_MIN_DIGITS     = 4;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1000;
    localparam int DEF_OPEN_CYCLES    = 5000;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROGRAM = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    // At most one of these is set after prioritisation.
    typedef struct packed {
        logic clear;
        logic enter;
        logic set;
        logic digit;
    } key_cmd_t;

    // clear > enter > set > digit; the losers of a same-cycle collision are dropped.
    function automatic key_cmd_t prioritize(input logic clear, input logic enter,
                                            input logic set, input logic valid);
        key_cmd_t c;
        c.clear = clear;
        c.enter = enter & ~clear;
        c.set   = set & ~clear & ~enter;
        c.digit = valid & ~clear & ~enter & ~set;
        return c;
    endfunction

endpackage

// File: rtl/passcode_checker_if.sv
// Keypad-side signal bundle of the passcode checker, plus the FSM state for observation.
// Key strobes are single-cycle qualifiers with no backpressure: every asserted strobe is consumed or dropped at the next clk edge.
interface passcode_checker_if
    import passcode_pkg::*;
#(
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int MAX_DIGITS = DEF_MAX_DIGITS
) ();

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic               key_valid;
    logic [DIGIT_W-1:0] key_code;
    logic               key_enter;
    logic               key_clear;
    logic               key_set;

    logic               unlocked;
    logic               fail_pulse;
    logic               locked_out;
    logic               prog_ok;
    logic               prog_err;
    logic [CNT_W-1:0]   entry_count;
    state_t             state_dbg;

    modport master (
        output key_valid, key_code, key_enter, key_clear, key_set,
        input  unlocked, fail_pulse, locked_out, prog_ok, prog_err, entry_count, state_dbg
    );

    modport slave (
        input  key_valid, key_code, key_enter, key_clear, key_set,
        output unlocked, fail_pulse, locked_out, prog_ok, prog_err, entry_count, state_dbg
    );

endinterface

// File: rtl/code_store.sv
// Digit store: MAX_DIGITS digits plus a length, whole-word write, parallel read.
// Reset and clr both return it to RESET_LEN zero digits (0 for the entry buffer, MIN_DIGITS for the code).
module code_store
    import passcode_pkg::*;
#(
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int MAX_DIGITS = DEF_MAX_DIGITS,
    parameter int RESET_LEN  = 0,
    parameter int LEN_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clr,
    input  logic                              we,
    input  logic [MAX_DIGITS-1:0][DIGIT_W-1:0] wr_digits,
    input  logic [LEN_W-1:0]                  wr_len,
    output logic [MAX_DIGITS-1:0][DIGIT_W-1:0] rd_digits,
    output logic [LEN_W-1:0]                  rd_len
);

    localparam logic [LEN_W-1:0] INIT_LEN = LEN_W'(RESET_LEN);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            rd_digits <= '0;
            rd_len    <= INIT_LEN;
        end else if (we) begin
            rd_digits <= wr_digits;
            rd_len    <= wr_len;
        end
    end

endmodule

// File: rtl/passcode_checker.sv
// Keypad passcode checker: buffers digits, compares against a programmable stored code,
// counts failures into a timed lockout, and auto-relocks after a period in OPEN.
module passcode_checker
    import passcode_pkg::*;
#(
    parameter int DIGIT_W        = DEF_DIGIT_W,
    parameter int RADIX          = DEF_RADIX,
    parameter int MAX_DIGITS     = DEF_MAX_DIGITS,
    parameter int MIN_DIGITS     = DEF_MIN_DIGITS,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES
) (
    input logic               clk,
    input logic               reset,
    passcode_checker_if.slave bus
);

    localparam int CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0]   MAX_LEN   = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0]   MIN_LEN   = CNT_W'(MIN_DIGITS);
    localparam logic [FAIL_W-1:0]  FAIL_LIM  = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]   LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]   OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [DIGIT_W:0]   RADIX_V   = (DIGIT_W + 1)'(RADIX);

    state_t              state, state_n;
    logic [FAIL_W-1:0]   fail_cnt, fail_cnt_n;
    logic [TMR_W-1:0]    tmr, tmr_n;
    logic                ovf, ovf_n;
    logic                fail_pulse_q, fail_pulse_n;
    logic                prog_ok_q, prog_ok_n;
    logic                prog_err_q, prog_err_n;

    logic                buf_clr, buf_append, code_we;
    logic [MAX_DIGITS-1:0][DIGIT_W-1:0] buf_digits, buf_wr_digits, code_digits;
    logic [CNT_W-1:0]    buf_len, buf_wr_len, code_len;

    key_cmd_t            cmd;
    logic                digit_legal, code_match, len_ok;

    assign cmd         = prioritize(bus.key_clear, bus.key_enter, bus.key_set, bus.key_valid);
    assign digit_legal = ({1'b0, bus.key_code} < RADIX_V);
    assign len_ok      = (buf_len >= MIN_LEN) && (buf_len <= MAX_LEN);
    assign buf_wr_len  = buf_len + 1'b1;

    // Append writes the whole word back with the new digit dropped into slot buf_len.
    always_comb begin
        buf_wr_digits = buf_digits;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (CNT_W'(i) == buf_len) buf_wr_digits[i] = bus.key_code;
        end
    end

    // Only the first len digits take part; an empty or overflowed entry never matches.
    always_comb begin
        code_match = (buf_len == code_len) && (buf_len != '0) && !ovf;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((CNT_W'(i) < buf_len) && (buf_digits[i] != code_digits[i])) code_match = 1'b0;
        end
    end

    code_store #(
        .DIGIT_W    (DIGIT_W),
        .MAX_DIGITS (MAX_DIGITS),
        .RESET_LEN  (0),
        .LEN_W      (CNT_W)
    ) u_entry_buf (
        .clk       (clk),
        .reset     (reset),
        .clr       (buf_clr),
        .we        (buf_append),
        .wr_digits (buf_wr_digits),
        .wr_len    (buf_wr_len),
        .rd_digits (buf_digits),
        .rd_len    (buf_len)
    );

    code_store #(
        .DIGIT_W    (DIGIT_W),
        .MAX_DIGITS (MAX_DIGITS),
        .RESET_LEN  (MIN_DIGITS),
        .LEN_W      (CNT_W)
    ) u_code (
        .clk       (clk),
        .reset     (reset),
        .clr       (1'b0),
        .we        (code_we),
        .wr_digits (buf_digits),
        .wr_len    (buf_len),
        .rd_digits (code_digits),
        .rd_len    (code_len)
    );

    always_comb begin
        state_n      = state;
        fail_cnt_n   = fail_cnt;
        tmr_n        = tmr;
        ovf_n        = ovf;
        fail_pulse_n = 1'b0;
        prog_ok_n    = 1'b0;
        prog_err_n   = 1'b0;
        buf_clr      = 1'b0;
        buf_append   = 1'b0;
        code_we      = 1'b0;

        unique case (state)
            ST_ENTRY, ST_PROGRAM: begin
                if (cmd.clear) begin
                    buf_clr = 1'b1;
                    ovf_n   = 1'b0;
                    if (state == ST_PROGRAM) begin
                        state_n = ST_OPEN;
                        tmr_n   = '0;
                    end
                end else if (cmd.enter) begin
                    if (state == ST_ENTRY) begin
                        state_n = ST_CHECK;
                    end else begin
                        if (len_ok && !ovf) begin
                            code_we   = 1'b1;
                            prog_ok_n = 1'b1;
                        end else begin
                            prog_err_n = 1'b1;
                        end
                        state_n = ST_OPEN;
                        tmr_n   = '0;
                        buf_clr = 1'b1;
                        ovf_n   = 1'b0;
                    end
                end else if (cmd.digit && digit_legal) begin
                    if (buf_len == MAX_LEN) ovf_n = 1'b1;
                    else                    buf_append = 1'b1;
                end
            end

            ST_CHECK: begin
                buf_clr = 1'b1;
                ovf_n   = 1'b0;
                if (code_match) begin
                    state_n    = ST_OPEN;
                    fail_cnt_n = '0;
                    tmr_n      = '0;
                end else begin
                    fail_pulse_n = 1'b1;
                    fail_cnt_n   = fail_cnt + 1'b1;
                    if (fail_cnt_n >= FAIL_LIM) begin
                        state_n = ST_LOCKOUT;
                        tmr_n   = '0;
                    end else begin
                        state_n = ST_ENTRY;
                    end
                end
            end

            // The timer is left untouched while in PROGRAM and restarts from zero on return.
            ST_OPEN: begin
                if (cmd.clear) begin
                    state_n = ST_ENTRY;
                    buf_clr = 1'b1;
                    ovf_n   = 1'b0;
                end else if (cmd.set) begin
                    state_n = ST_PROGRAM;
                    buf_clr = 1'b1;
                    ovf_n   = 1'b0;
                end else if (tmr == OPEN_LAST) begin
                    state_n = ST_ENTRY;
                    buf_clr = 1'b1;
                    ovf_n   = 1'b0;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end

            ST_LOCKOUT: begin
                if (tmr == LOCK_LAST) begin
                    state_n    = ST_ENTRY;
                    fail_cnt_n = '0;
                    tmr_n      = '0;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end

            default: begin
                state_n = ST_ENTRY;
                buf_clr = 1'b1;
                ovf_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_ENTRY;
            fail_cnt     <= '0;
            tmr          <= '0;
            ovf          <= 1'b0;
            fail_pulse_q <= 1'b0;
            prog_ok_q    <= 1'b0;
            prog_err_q   <= 1'b0;
        end else begin
            state        <= state_n;
            fail_cnt     <= fail_cnt_n;
            tmr          <= tmr_n;
            ovf          <= ovf_n;
            fail_pulse_q <= fail_pulse_n;
            prog_ok_q    <= prog_ok_n;
            prog_err_q   <= prog_err_n;
        end
    end

    assign bus.unlocked    = (state == ST_OPEN);
    assign bus.locked_out  = (state == ST_LOCKOUT);
    assign bus.fail_pulse  = fail_pulse_q;
    assign bus.prog_ok     = prog_ok_q;
    assign bus.prog_err    = prog_err_q;
    assign bus.entry_count = buf_len;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_passcode_checker.sv
// Directed bench for passcode_checker: a vector table for the basic flows, then
// hand-written sequences for lockout, overflow, programming, reset precedence and relock timing.
module tb_passcode_checker;
    import passcode_pkg::*;

    localparam int LOCK_CYC = 1000;
    localparam int OPEN_CYC = 5000;

    typedef struct {
        logic       v;
        logic [3:0] code;
        logic       e;
        logic       c;
        logic       s;
        logic [10:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    vec_t        tbl[$];
    logic [10:0] exp_q[$];

    passcode_checker_if #(.DIGIT_W(4), .MAX_DIGITS(6)) bus ();

    passcode_checker #(
        .DIGIT_W(4), .RADIX(10), .MAX_DIGITS(6), .MIN_DIGITS(4),
        .MAX_FAILS(3), .LOCKOUT_CYCLES(LOCK_CYC), .OPEN_CYCLES(OPEN_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] pk(input logic u, input logic f, input logic l,
                                       input logic ok, input logic er,
                                       input logic [2:0] cnt, input state_t st);
        return {u, f, l, ok, er, cnt, st};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // packed {unlocked, fail_pulse, locked_out, prog_ok, prog_err, entry_count, state}
    task automatic expect_outs(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {bus.unlocked, bus.fail_pulse, bus.locked_out, bus.prog_ok, bus.prog_err,
               bus.entry_count, bus.state_dbg};
        check(name, 32'(act), 32'(exp));
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] code, input logic e,
                         input logic c, input logic s);
        bus.key_valid = v;
        bus.key_code  = code;
        bus.key_enter = e;
        bus.key_clear = c;
        bus.key_set   = s;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;
        bus.key_set   = 1'b0;
    endtask

    task automatic type_code(input logic [31:0] digs, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, digs[4*(n-1-i) +: 4], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_enter(); drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
    task automatic press_clear(); drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
    task automatic press_set();   drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask

    // enter then one idle edge, so the CHECK result is visible
    task automatic submit_code(input logic [31:0] digs, input int n);
        type_code(digs, n);
        press_enter();
        tick();
    endtask

    // reset held low while keys are active; outputs must be in their reset state
    task automatic do_reset(input string name);
        reset = 1'b0;
        drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
        expect_outs(name, pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));
        reset = 1'b1;
    endtask

    task automatic add_vec(input logic v, input logic [3:0] code, input logic e, input logic c,
                           input logic s, input logic [10:0] exp);
        vec_t t;
        t.v = v; t.code = code; t.e = e; t.c = c; t.s = s; t.exp = exp;
        tbl.push_back(t);
        exp_q.push_back(exp);
    endtask

    initial begin
        int bad;
        logic [10:0] exp_w;

        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;
        bus.key_set   = 1'b0;

        // default code 0000 opens; programming 12345; wrong code fails
        for (int k = 1; k <= 4; k++) add_vec(1, 4'd0, 0, 0, 0, pk(0, 0, 0, 0, 0, 3'(k), ST_ENTRY));
        add_vec(0, 4'd0, 1, 0, 0, pk(0, 0, 0, 0, 0, 3'd4, ST_CHECK));
        add_vec(0, 4'd0, 0, 0, 0, pk(1, 0, 0, 0, 0, 3'd0, ST_OPEN));
        add_vec(0, 4'd0, 0, 0, 1, pk(0, 0, 0, 0, 0, 3'd0, ST_PROGRAM));
        for (int k = 1; k <= 5; k++) add_vec(1, 4'(k), 0, 0, 0, pk(0, 0, 0, 0, 0, 3'(k), ST_PROGRAM));
        add_vec(0, 4'd0, 1, 0, 0, pk(1, 0, 0, 1, 0, 3'd0, ST_OPEN));
        add_vec(0, 4'd0, 0, 1, 0, pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));
        for (int k = 1; k <= 5; k++) add_vec(1, 4'(k), 0, 0, 0, pk(0, 0, 0, 0, 0, 3'(k), ST_ENTRY));
        add_vec(0, 4'd0, 1, 0, 0, pk(0, 0, 0, 0, 0, 3'd5, ST_CHECK));
        add_vec(0, 4'd0, 0, 0, 0, pk(1, 0, 0, 0, 0, 3'd0, ST_OPEN));
        add_vec(0, 4'd0, 0, 1, 0, pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));
        for (int k = 1; k <= 4; k++) add_vec(1, 4'(k), 0, 0, 0, pk(0, 0, 0, 0, 0, 3'(k), ST_ENTRY));
        add_vec(0, 4'd0, 1, 0, 0, pk(0, 0, 0, 0, 0, 3'd4, ST_CHECK));
        add_vec(0, 4'd0, 0, 0, 0, pk(0, 1, 0, 0, 0, 3'd0, ST_ENTRY));
        add_vec(0, 4'd0, 0, 0, 0, pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));
        // illegal digit ignored; clear beats enter; set beats digit
        add_vec(1, 4'd1, 0, 0, 0, pk(0, 0, 0, 0, 0, 3'd1, ST_ENTRY));
        add_vec(1, 4'd12, 0, 0, 0, pk(0, 0, 0, 0, 0, 3'd1, ST_ENTRY));
        add_vec(1, 4'd2, 0, 0, 0, pk(0, 0, 0, 0, 0, 3'd2, ST_ENTRY));
        add_vec(0, 4'd0, 1, 1, 0, pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));
        add_vec(0, 4'd0, 0, 0, 0, pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));
        add_vec(1, 4'd7, 0, 0, 1, pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));
        // enter with an empty buffer is a mismatch
        add_vec(1, 4'd5, 1, 0, 1, pk(0, 0, 0, 0, 0, 3'd0, ST_CHECK));
        add_vec(0, 4'd0, 0, 0, 0, pk(0, 1, 0, 0, 0, 3'd0, ST_ENTRY));

        do_reset("reset_initial");

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].code, tbl[i].e, tbl[i].c, tbl[i].s);
            exp_w = exp_q.pop_front();
            expect_outs($sformatf("vec%0d", i), exp_w);
        end

        // three wrong codes -> lockout that ignores keys for exactly LOCK_CYC cycles
        do_reset("reset_before_lockout");
        submit_code(32'h1111, 4);
        expect_outs("lock_fail1", pk(0, 1, 0, 0, 0, 3'd0, ST_ENTRY));
        submit_code(32'h2222, 4);
        expect_outs("lock_fail2", pk(0, 1, 0, 0, 0, 3'd0, ST_ENTRY));
        submit_code(32'h3333, 4);
        expect_outs("lock_enter", pk(0, 1, 1, 0, 0, 3'd0, ST_LOCKOUT));
        bad = 0;
        for (int i = 1; i < LOCK_CYC; i++) begin
            case (i % 4)
                0:       drive(1'b1, 4'(i % 10), 1'b0, 1'b0, 1'b0);
                1:       drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
                2:       drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
                default: drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            endcase
            if (!bus.locked_out || bus.entry_count != 3'd0 || bus.fail_pulse || bus.unlocked) bad++;
        end
        check("lockout_hold_bad_cycles", 32'(bad), 32'd0);
        tick();
        expect_outs("lockout_exit", pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));
        submit_code(32'h1111, 4);
        expect_outs("post_lock_fail1", pk(0, 1, 0, 0, 0, 3'd0, ST_ENTRY));
        submit_code(32'h1111, 4);
        expect_outs("post_lock_fail2", pk(0, 1, 0, 0, 0, 3'd0, ST_ENTRY));
        submit_code(32'h0000, 4);
        expect_outs("post_lock_open", pk(1, 0, 0, 0, 0, 3'd0, ST_OPEN));

        // program a 6-digit code, then overflow and bad-length attempts
        press_set();
        type_code(32'h123456, 6);
        press_enter();
        expect_outs("prog6_ok", pk(1, 0, 0, 1, 0, 3'd0, ST_OPEN));
        press_clear();
        type_code(32'h1234567, 7);
        expect_outs("overflow_saturate", pk(0, 0, 0, 0, 0, 3'd6, ST_ENTRY));
        press_enter();
        tick();
        expect_outs("overflow_fail", pk(0, 1, 0, 0, 0, 3'd0, ST_ENTRY));
        submit_code(32'h123456, 6);
        expect_outs("code6_open", pk(1, 0, 0, 0, 0, 3'd0, ST_OPEN));
        press_set();
        type_code(32'h789, 3);
        press_enter();
        expect_outs("prog3_err", pk(1, 0, 0, 0, 1, 3'd0, ST_OPEN));
        press_set();
        type_code(32'h1234567, 7);
        press_enter();
        expect_outs("prog_ovf_err", pk(1, 0, 0, 0, 1, 3'd0, ST_OPEN));
        press_set();
        type_code(32'h9999, 4);
        press_clear();
        expect_outs("prog_abort", pk(1, 0, 0, 0, 0, 3'd0, ST_OPEN));
        press_clear();
        submit_code(32'h123456, 6);
        expect_outs("code_unchanged", pk(1, 0, 0, 0, 0, 3'd0, ST_OPEN));

        // reset wins over enter in PROGRAM; stored code back to 0000
        press_set();
        type_code(32'h5555, 4);
        expect_outs("in_program", pk(0, 0, 0, 0, 0, 3'd4, ST_PROGRAM));
        reset = 1'b0;
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_outs("reset_mid_program", pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));
        reset = 1'b1;
        submit_code(32'h0000, 4);
        expect_outs("code_reset_after_prog", pk(1, 0, 0, 0, 0, 3'd0, ST_OPEN));

        // reset in LOCKOUT; stored code back to 0000
        press_set();
        type_code(32'h5555, 4);
        press_enter();
        expect_outs("prog5555_ok", pk(1, 0, 0, 1, 0, 3'd0, ST_OPEN));
        press_clear();
        for (int a = 0; a < 3; a++) submit_code(32'h0000, 4);
        expect_outs("lock_again", pk(0, 1, 1, 0, 0, 3'd0, ST_LOCKOUT));
        for (int i = 0; i < 10; i++) tick();
        do_reset("reset_mid_lockout");
        submit_code(32'h0000, 4);
        expect_outs("code_reset_after_lock", pk(1, 0, 0, 0, 0, 3'd0, ST_OPEN));

        // OPEN lasts exactly OPEN_CYC cycles
        bad = 0;
        for (int i = 1; i < OPEN_CYC; i++) begin
            tick();
            if (!bus.unlocked) bad++;
        end
        check("open_hold_bad_cycles", 32'(bad), 32'd0);
        tick();
        expect_outs("open_timeout", pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));

        // the timer restarts after returning from PROGRAM
        submit_code(32'h0000, 4);
        for (int i = 0; i < 100; i++) tick();
        press_set();
        for (int i = 0; i < 200; i++) tick();
        press_clear();
        expect_outs("back_to_open", pk(1, 0, 0, 0, 0, 3'd0, ST_OPEN));
        bad = 0;
        for (int i = 1; i < OPEN_CYC; i++) begin
            tick();
            if (!bus.unlocked) bad++;
        end
        check("open_restart_bad_cycles", 32'(bad), 32'd0);
        tick();
        expect_outs("open_restart_timeout", pk(0, 0, 0, 0, 0, 3'd0, ST_ENTRY));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/passcode_checker.md
PASSCODE_CHECKER -- requirements
Module: passcode_checker

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter: DIGIT_W, default 4, bits per digit.
REQ-003 Parameter: RADIX, default 10, legal digit values are 0..RADIX-1.
REQ-004 Parameter: MAX_DIGITS, default 6, capacity of the entry buffer and the code store.
REQ-005 Parameter: MIN_DIGITS, default 4, minimum length of a programmed code.
REQ-006 Parameter: MAX_FAILS, default 3, consecutive failed attempts before lockout.
REQ-007 Parameter: LOCKOUT_CYCLES, default 1000, lockout duration in clk cycles.
REQ-008 Parameter: OPEN_CYCLES, default 5000, auto-relock timeout in clk cycles.
REQ-009 Port: clk  in  1  rising-edge clock.
REQ-010 Port: reset  in  1  synchronous active-low reset.
REQ-011 Port: key_valid  in  1  one-cycle strobe that qualifies key_code.
REQ-012 Port: key_code  in  DIGIT_W  digit value.
REQ-013 Port: key_enter  in  1  submit strobe ('*').
REQ-014 Port: key_clear  in  1  discard entry, or relock when OPEN.
REQ-015 Port: key_set  in  1  request to program a new code; honoured in OPEN only.
REQ-016 Port: unlocked  out  1  high while in OPEN.
REQ-017 Port: fail_pulse  out  1  one-cycle pulse per rejected attempt.
REQ-018 Port: locked_out  out  1  high while in LOCKOUT.
REQ-019 Port: prog_ok / prog_err  out  1 each  one-cycle result of a programming attempt.
REQ-020 Port: entry_count  out  $clog2(MAX_DIGITS+1)  number of digits currently buffered.

Function
REQ-021 The FSM SHALL have the states ENTRY, CHECK, OPEN, PROGRAM and LOCKOUT, and SHALL be in ENTRY after reset.
REQ-022 Input priority within one cycle SHALL be key_clear > key_enter > key_set > key_valid; lower-priority strobes in the same cycle are dropped.
REQ-023 In ENTRY or PROGRAM, key_valid with key_code < RADIX SHALL append the digit and increment entry_count; a key_code >= RADIX SHALL be ignored.
REQ-024 A digit arriving when entry_count == MAX_DIGITS SHALL be discarded and SHALL set an overflow flag; the count saturates.
REQ-025 key_enter sampled at edge k in ENTRY SHALL move the FSM to CHECK; at edge k+1 the result is registered.
  - match (length equal, all digits equal, no overflow): go to OPEN, clear the fail counter.
  - mismatch: pulse fail_pulse for one cycle and increment the fail counter; if the counter reaches MAX_FAILS go to LOCKOUT, otherwise return to ENTRY.
REQ-026 The entry buffer, entry_count and the overflow flag SHALL be cleared on leaving CHECK, on key_clear, and on entry to PROGRAM.
REQ-027 key_enter with zero digits in ENTRY SHALL count as a mismatch.
REQ-028 OPEN SHALL exit to ENTRY on key_clear or after OPEN_CYCLES cycles; key_set SHALL move it to PROGRAM.
REQ-029 In PROGRAM, key_enter with MIN_DIGITS <= count <= MAX_DIGITS and no overflow SHALL write the buffer and length to the code store, pulse prog_ok and return to OPEN.
REQ-030 In PROGRAM, key_enter with any other count, or with overflow set, SHALL pulse prog_err, leave the stored code unchanged and return to OPEN.
REQ-031 In PROGRAM, key_clear SHALL abort to OPEN without writing the code store.
REQ-032 The OPEN timer SHALL pause during PROGRAM and restart on returning to OPEN.
REQ-033 In LOCKOUT all key inputs SHALL be ignored; after exactly LOCKOUT_CYCLES cycles the FSM SHALL enter ENTRY with the fail counter cleared.

Reset
REQ-034 When reset is low at an edge, all of the following SHALL take effect:
  - state = ENTRY; unlocked, fail_pulse, locked_out, prog_ok, prog_err = 0; entry_count = 0.
  - fail counter, timers and overflow flag cleared.
  - code store = MIN_DIGITS zeros.
REQ-035 Reset SHALL take precedence over every other input, including reset asserted mid-PROGRAM and mid-LOCKOUT.

Structure
REQ-036 A shared package passcode_pkg SHALL hold the state enum and the default parameter constants.
REQ-037 The digit storage (MAX_DIGITS x DIGIT_W plus length, with write enable and parallel read) SHALL be one sub-module, code_store, instantiated for both the entry buffer and the stored code.

Verification
REQ-038 Reset, then digits 0,0,0,0 and enter -> unlocked=1 two cycles after enter; fail_pulse never asserted.
REQ-039 From OPEN: key_set, digits 1,2,3,4,5 and enter -> prog_ok; then key_clear; then 1,2,3,4,5 + enter -> unlocked; then 1,2,3,4 + enter -> fail_pulse.
REQ-040 Three wrong codes -> locked_out=1; any keys ignored for 1000 cycles; then ENTRY with the fail counter at 0.
REQ-041 Seven digits then enter -> fail (overflow); in PROGRAM, 3 digits + enter -> prog_err and the stored code unchanged.
REQ-042 key_clear and key_enter in the same cycle -> buffer cleared, no CHECK; key_code=12 ignored, entry_count unchanged.
REQ-043 reset low in PROGRAM and in LOCKOUT -> all outputs 0 and the code returns to 0000.
